// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nibble_serial_add_ctrl_pkg: shared state encoding and sizing constants for the nibble-serial adder
package nibble_serial_add_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int SLICE_W = 4;
   localparam int NIBBLES_DEF = 4;
endpackage

// File: rtl/nibble_serial_add_ctrl_adder_slice4.sv
// adder_slice4: 4-bit ripple-carry slice built from 1-bit full adders
module adder_slice4
   import nibble_serial_add_ctrl_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               carryin,
   output logic [SLICE_W-1:0] sum,
   output logic               carryout,
   output logic               carry_into_msb
);
   logic [SLICE_W:0] c;
   assign c[0] = carryin;
   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign carryout       = c[SLICE_W];
   assign carry_into_msb = c[SLICE_W-1];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: time-multiplexes one 4-bit adder slice to add two W-bit operands
// one nibble per cycle, with valid/ready handshakes on both sides and abort support.
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SLICE_W*NIBBLES-1:0] a,
   input  logic [SLICE_W*NIBBLES-1:0] b,
   input  logic                       abort,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SLICE_W*NIBBLES-1:0] sum,
   output logic                       carryout,
   output logic                       overflow,
   output logic                       busy
);
   localparam int W  = SLICE_W * NIBBLES;
   localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   state_t state;
   logic [W-1:0] a_q, b_q;
   logic [CW-1:0] cnt;
   logic carry;
   logic [SLICE_W-1:0] s_sum;
   logic s_co, s_c3;
   adder_slice4 u_slice (
      .a              (a_q[SLICE_W*int'(cnt) +: SLICE_W]),
      .b              (b_q[SLICE_W*int'(cnt) +: SLICE_W]),
      .carryin        (carry),
      .sum            (s_sum),
      .carryout       (s_co),
      .carry_into_msb (s_c3)
   );
   assign in_ready  = state == IDLE;
   assign busy      = state == RUN;
   assign out_valid = state == DONE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         sum      <= '0;
         carryout <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q   <= a;
               b_q   <= b;
               cnt   <= '0;
               carry <= 1'b0;
               state <= RUN;
            end
            RUN: if (abort) begin
               carryout <= 1'b0;
               overflow <= 1'b0;
               state    <= IDLE;
            end else begin
               sum[SLICE_W*int'(cnt) +: SLICE_W] <= s_sum;
               carry <= s_co;
               cnt   <= cnt + 1'b1;
               // signed overflow is judged only on the most significant slice
               if (cnt == CW'(NIBBLES - 1)) begin
                  carryout <= s_co;
                  overflow <= s_co ^ s_c3;
                  state    <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 in_valid  input  1  requester presents operands.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  W  first operand, 2's complement.
REQ-007 b  input  W  second operand, 2's complement.
REQ-008 abort  input  1  cancels an operation in progress.
REQ-009 out_valid  output  1  result is held on sum/carryout/overflow.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  W  registered sum a+b, modulo 2^W.
REQ-012 carryout  output  1  unsigned carry out of bit W-1.
REQ-013 overflow  output  1  signed overflow of the W-bit addition.
REQ-014 busy  output  1  high in RUN state.

Function
REQ-015 FSM states: IDLE, RUN, DONE; exactly one active at a time.
REQ-016 IDLE: in_ready=1, out_valid=0, busy=0.
REQ-017 IDLE with in_valid=1: latch a and b, clear nibble counter and carry register, go to RUN on the same edge.
REQ-018 RUN: each cycle, add nibble cnt of the latched operands with the carry register through one 4-bit slice; write the slice sum into sum[4*cnt+3:4*cnt]; load the slice carry-out into the carry register; increment cnt.
REQ-019 RUN on last nibble (cnt=NIBBLES-1): set carryout to the slice carry-out, set overflow to slice carry-out XOR carry into slice bit 3, then go to DONE.
REQ-020 Latency: out_valid rises exactly NIBBLES cycles after the accepting edge (4 cycles at default).
REQ-021 DONE: out_valid=1; sum, carryout and overflow stay stable until the handshake completes.
REQ-022 DONE with out_ready=1: go to IDLE; out_valid drops on the next cycle.
REQ-023 in_ready=0 in RUN and DONE; in_valid is ignored there, with no queuing. Back-to-back throughput is one operation per NIBBLES+2 cycles when out_ready is held high.
REQ-024 abort=1 in RUN: go to IDLE next edge, with no out_valid; sum contents are don't-care, and carryout/overflow are cleared.
REQ-025 abort in IDLE or DONE has no effect; abort takes priority over the last-nibble transition.
REQ-026 Latched operands do not change while in RUN, even if a or b change.
REQ-027 The nibble counter is log2(NIBBLES) bits wide (min 1) and is never compared beyond NIBBLES-1.

Reset
REQ-028 reset=1 at a rising edge: state goes to IDLE, and sum, carryout, overflow, carry register and counter are cleared to 0.
REQ-029 Reset overrides all other inputs, including mid-RUN and mid-DONE; no out_valid follows a reset.
REQ-030 Output values in the first cycle after reset deassertion: in_ready=1, out_valid=0, busy=0.

Structure
REQ-031 A shared package holds the state enumeration (IDLE, RUN, DONE), SLICE_W=4 and the default NIBBLES.
REQ-032 Sub-module adder_slice4: 4-bit ripple-carry slice with ports sum[3:0], carryout, carry_into_msb, a[3:0], b[3:0], carryin; it is built from 1-bit full adders.
REQ-033 Exactly one adder_slice4 instance is used; the block is a time-multiplexed controller around it.

Verification
REQ-034 a=0x1234, b=0x4321, out_ready=1 -> out_valid 4 cycles after accept; sum=0x5555, carryout=0, overflow=0.
REQ-035 a=0x7FFF, b=0x0001 -> sum=0x8000, carryout=0, overflow=1 (inter-nibble carry ripples through all 4 steps).
REQ-036 a=0xFFFF, b=0x0001 -> sum=0x0000, carryout=1, overflow=0. Then a=0x8000, b=0x8000 -> sum=0x0000, carryout=1, overflow=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> result is stable, in_ready=0, and the new operands are not accepted until after the handshake.
REQ-038 abort asserted on the 2nd RUN cycle -> IDLE next cycle, no out_valid pulse. A subsequent op a=0x0003, b=0x0004 -> sum=0x0007 with carry register cleared.
REQ-039 reset asserted on the 3rd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; a following accept completes normally.
